// File: rtl/fb_sched_pkg.sv
// Shared state encoding and handshake codes for the frame-buffer sweep scheduler.
package fb_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RENDER,
    WAIT_SWAP,
    SWAP
  } sched_state_t;

  localparam logic [1:0] FB_RTS_NONE     = 2'b00;
  localparam logic [1:0] FB_RTS_RENDERED = 2'b01;
  localparam logic [1:0] FB_RTS_SWAP     = 2'b11;

endpackage

// File: rtl/sweep_watchdog.sv
// Counts cycles while a sweep renders; flags the cycle in which the budget runs out.
module sweep_watchdog #(
  parameter logic [23:0] SWEEP_TIMEOUT = 24'd2_000_000
) (
  input  logic pixel_clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [23:0] count_reg;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 24'd1;
    end
  end

  // Combinational so the scheduler can abandon the sweep in the same cycle.
  assign expired = enable && (count_reg == SWEEP_TIMEOUT - 24'd1);

endmodule

// File: rtl/fb_sweep_scheduler.sv
// Frame scheduler: starts DDA sweeps, waits for the last pixel, swaps the
// double-buffered frame buffer on a display frame boundary.
module fb_sweep_scheduler
  import fb_sched_pkg::*;
#(
  parameter logic [23:0] SWEEP_TIMEOUT = 24'd2_000_000,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                 pixel_clk_in,
  input  logic                 rst_in,
  input  logic                 run_in,
  input  logic                 display_frame_end_in,
  input  logic                 ray_last_pixel_in,
  output logic                 sweep_start_out,
  output logic [1:0]           fb_ready_to_switch_out,
  output logic                 write_buf_sel_out,
  output logic                 read_buf_sel_out,
  output logic [CNT_WIDTH-1:0] frame_count_out,
  output logic [CNT_WIDTH-1:0] dropped_frames_out,
  output logic                 timeout_err_out,
  output logic                 busy_out
);

  sched_state_t state_reg, state_next;
  logic         sweep_start_next;
  logic [1:0]   rts_next;
  logic         busy_next;
  logic         wd_expired;

  sweep_watchdog #(.SWEEP_TIMEOUT(SWEEP_TIMEOUT)) u_watchdog (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .clear        (state_reg == START),
    .enable       (state_reg == RENDER),
    .expired      (wd_expired)
  );

  // State register; the state-decoded outputs are registered alongside it.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg              <= IDLE;
      sweep_start_out        <= 1'b0;
      fb_ready_to_switch_out <= FB_RTS_NONE;
      busy_out               <= 1'b0;
    end else begin
      state_reg              <= state_next;
      sweep_start_out        <= sweep_start_next;
      fb_ready_to_switch_out <= rts_next;
      busy_out               <= busy_next;
    end
  end

  // A finished sweep outranks a watchdog expiry landing in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (run_in && display_frame_end_in) state_next = START;
      START:     state_next = RENDER;
      RENDER: begin
        if (ray_last_pixel_in) begin
          state_next = display_frame_end_in ? SWAP : WAIT_SWAP;
        end else if (wd_expired) begin
          state_next = START;
        end
      end
      WAIT_SWAP: if (display_frame_end_in) state_next = SWAP;
      SWAP:      state_next = run_in ? START : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Decoded from the next state so each output lines up with the state it belongs to.
  always_comb begin
    sweep_start_next = (state_next == START);
    busy_next        = (state_next != IDLE);
    case (state_next)
      WAIT_SWAP: rts_next = FB_RTS_RENDERED;
      SWAP:      rts_next = FB_RTS_SWAP;
      default:   rts_next = FB_RTS_NONE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      write_buf_sel_out  <= 1'b0;
      read_buf_sel_out   <= 1'b1;
      frame_count_out    <= '0;
      dropped_frames_out <= '0;
      timeout_err_out    <= 1'b0;
    end else begin
      if (state_reg == SWAP) begin
        write_buf_sel_out <= ~write_buf_sel_out;
        read_buf_sel_out  <= write_buf_sel_out;
        frame_count_out   <= frame_count_out + CNT_WIDTH'(1);
      end
      if (state_reg == RENDER && display_frame_end_in && !ray_last_pixel_in &&
          dropped_frames_out != '1) begin
        dropped_frames_out <= dropped_frames_out + CNT_WIDTH'(1);
      end
      if (state_reg == RENDER && !ray_last_pixel_in && wd_expired) begin
        timeout_err_out <= 1'b1;
      end
    end
  end

endmodule
